// File: rtl/alu_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rx_pkg
//  Brief    : Shared types and the CRC4 helper for the mtm_Alu serial receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_rx_pkg;

  // Packet kind carried in the bit after the start bit
  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CMD  = 1'b1
  } pkt_type_e;

  // One serial packet as it appears on the line, MSB first
  typedef struct packed {
    logic       start;
    pkt_type_e  ptype;
    logic [7:0] payload;
    logic       stop;
  } packet_t;

  // Operations the execute stage supports
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  // Serial CRC, polynomial x^4+x+1, zero init, d[67] shifted in first
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rx_deframer
//  Brief    : Bit-level FSM that recovers start/type/payload/stop packets
//             from the serial line and reports each one with a 1-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rx_deframer #(
  parameter int PACKET_BITS = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_payload,
  output logic       pkt_drop
);

  localparam int         c_payload_bits = PACKET_BITS - 3;
  localparam logic [3:0] c_last_bit     = 4'(c_payload_bits - 1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_type    = 2'd1;
  localparam logic [1:0] c_st_payload = 2'd2;
  localparam logic [1:0] c_st_stop    = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_type;
  logic       w_in_type;
  logic       w_in_payload;
  logic       w_accept;
  logic       w_drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: a bad stop bit also returns to idle, the top discards the frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (!sin) w_state_nxt = c_st_type;
      c_st_type:    w_state_nxt = c_st_payload;
      c_st_payload: if (r_bitcnt == c_last_bit) w_state_nxt = c_st_stop;
      c_st_stop:    w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // State decode driving the datapath
  always_comb begin
    w_in_type    = (r_state == c_st_type);
    w_in_payload = (r_state == c_st_payload);
    w_accept     = (r_state == c_st_stop) &  sin;
    w_drop       = (r_state == c_st_stop) & ~sin;
  end

  // Payload shifter and registered packet report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_type      <= 1'b0;
      pkt_valid   <= 1'b0;
      pkt_drop    <= 1'b0;
      pkt_type    <= 1'b0;
      pkt_payload <= 8'h00;
    end else begin
      pkt_valid <= w_accept;
      pkt_drop  <= w_drop;
      if (w_in_type) begin
        r_type   <= sin;
        r_bitcnt <= 4'd0;
      end
      if (w_in_payload) begin
        r_shift  <= {r_shift[6:0], sin};
        r_bitcnt <= r_bitcnt + 4'd1;
      end
      if (w_accept) begin
        pkt_type    <= r_type;
        pkt_payload <= r_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_rx
//  Brief    : Serial deframer for mtm_Alu: collects data/command packets,
//             checks count/CRC/opcode and hands one record to execute.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_serial_rx
  import alu_rx_pkg::*;
#(
  parameter int DATA_PACKETS = 8,
  parameter int PACKET_BITS  = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic        out_err_data,
  output logic        out_err_crc,
  output logic        out_err_op,
  output logic        out_overrun
);

  localparam int                 c_cnt_w = $clog2(DATA_PACKETS + 1);
  localparam int                 c_idx_w = $clog2(DATA_PACKETS);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DATA_PACKETS);

  logic                        w_pkt_valid;
  logic                        w_pkt_type;
  logic [7:0]                  w_pkt_payload;
  logic                        w_pkt_drop;
  logic [c_cnt_w-1:0]          r_cnt;
  logic                        r_extra;
  logic [DATA_PACKETS-1:0][7:0] r_slots;
  logic [31:0]                 w_a;
  logic [31:0]                 w_b;
  logic [2:0]                  w_op;
  logic                        w_op_ok;
  logic                        w_cmd;
  logic                        w_dat;
  logic                        w_err_data;
  logic                        w_err_crc;
  logic                        w_err_op;
  logic                        w_unused_rsvd;

  alu_rx_deframer #(
    .PACKET_BITS (PACKET_BITS)
  ) u_deframer (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .pkt_valid   (w_pkt_valid),
    .pkt_type    (w_pkt_type),
    .pkt_payload (w_pkt_payload),
    .pkt_drop    (w_pkt_drop)
  );

  assign w_cmd         = w_pkt_valid & (w_pkt_type == PKT_CMD);
  assign w_dat         = w_pkt_valid & (w_pkt_type == PKT_DATA);
  assign w_op          = w_pkt_payload[6:4];
  assign w_unused_rsvd = w_pkt_payload[7];
  assign w_a           = {r_slots[0], r_slots[1], r_slots[2], r_slots[3]};
  assign w_b           = {r_slots[4], r_slots[5], r_slots[6], r_slots[7]};

  // Opcode legality and frame checks, evaluated while the command pulse is up
  always_comb begin
    w_op_ok = 1'b0;
    case (w_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: w_op_ok = 1'b1;
      default:                       w_op_ok = 1'b0;
    endcase
    w_err_data = (r_cnt != c_full) | r_extra;
    w_err_crc  = ~w_err_data & (w_pkt_payload[3:0] != crc4({w_a, w_b, 1'b1, w_op}));
    w_err_op   = ~w_err_data & ~w_err_crc & ~w_op_ok;
  end

  // Frame assembly: slots fill in arrival order, any frame end clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_extra <= 1'b0;
      r_slots <= '0;
    end else if (w_pkt_drop | w_cmd) begin
      r_cnt   <= '0;
      r_extra <= 1'b0;
      r_slots <= '0;
    end else if (w_dat) begin
      if (r_cnt < c_full) begin
        r_slots[r_cnt[c_idx_w-1:0]] <= w_pkt_payload;
        r_cnt                       <= r_cnt + 1'b1;
      end else begin
        r_extra <= 1'b1;
      end
    end
  end

  // Result record and handshake; a new record always wins over a pending one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_a        <= 32'h0;
      out_b        <= 32'h0;
      out_op       <= 3'b000;
      out_err_data <= 1'b0;
      out_err_crc  <= 1'b0;
      out_err_op   <= 1'b0;
      out_overrun  <= 1'b0;
    end else if (w_cmd) begin
      out_valid    <= 1'b1;
      out_a        <= w_a;
      out_b        <= w_b;
      out_op       <= w_op;
      out_err_data <= w_err_data;
      out_err_crc  <= w_err_crc;
      out_err_op   <= w_err_op;
      if (out_valid & ~out_ready) out_overrun <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
Serial input deframer for mtm_Alu, sitting directly behind the sin pin and feeding the ALU datapath.
- Samples sin one bit per clock and recovers 11-bit packets.
- Collects 8 data bytes and 1 command byte, then checks packet count, CRC4 and opcode.
- Presents one result record (A, B, op, error flags) to the execute stage over a valid/ready handshake.

Parameters:
DATA_PACKETS, 8, data packets expected before a command packet (4 for A, 4 for B).
PACKET_BITS, 11, packet length in bits including start and stop.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sin  in  1  serial input, idle high, sampled on rising clk
out_valid  out  1  result record valid
out_ready  in  1  consumer accepts record when high with out_valid
out_a  out  32  operand A (first four data bytes, MSB byte first)
out_b  out  32  operand B (next four data bytes, MSB byte first)
out_op  out  3  operation code from command byte
out_err_data  out  1  wrong number of data packets before command
out_err_crc  out  1  CRC mismatch
out_err_op  out  1  unsupported opcode
out_overrun  out  1  sticky: record lost because previous one not yet accepted

Behaviour:
- Reset: all outputs 0, bit FSM in IDLE, data counter 0, assembly registers 0. Asserting rst_n low mid-packet aborts the packet immediately with nothing reported.
- Packet, MSB first: start 0, type (0 data / 1 cmd), payload[7:0], stop 1.
- Bit FSM:
  - IDLE: sin==0 -> TYPE.
  - TYPE: latch type -> PAYLOAD with count 0.
  - PAYLOAD: shift 8 bits -> STOP.
  - STOP: if sin==1, the packet is accepted. If sin==0, the packet is dropped, the frame is discarded (data counter cleared) and the FSM returns to IDLE.
  - An idle-high line keeps the FSM in IDLE indefinitely.
- Data packet accepted:
  - Counter < 8: store byte in slot[counter], counter++.
  - Counter == 8: extra-data flag set, byte discarded.
- Command packet accepted: payload = {rsvd, op[2:0], crc[3:0]}.
  - out_err_data = (counter != 8) | extra flag.
  - out_err_crc = !err_data & (crc != crc4({A, B, 1'b1, op})).
  - out_err_op = !err_data & !err_crc & op not in {000, 001, 100, 101}.
  - Record is loaded; counter and extra flag are cleared.
- CRC4: polynomial x^4+x+1, init 0, over 68 bits d = {A, B, 1'b1, op}, d[67] first.
- Latency: out_valid rises on the clk edge after the edge that samples the command stop bit.
- Handshake:
  - out_valid holds, with outputs stable, until a cycle with out_valid & out_ready.
  - out_valid falls on the following edge unless a new record loads on that same edge; then it stays high with the new contents.
  - New record while out_valid & !out_ready: new record overwrites, out_overrun set (sticky until reset).
- Back-to-back packets with no idle bits are supported: the next start bit may be sampled on the edge after the stop bit.
- A command packet with zero data packets produces err_data only; out_a and out_b hold 0 from the cleared slots.

Decomposition:
- Package alu_rx_pkg holds:
  - packet_t (11 bits) and the packet type enum (DATA = 0, CMD = 1);
  - operation_t enum (AND 000, OR 001, ADD 100, SUB 101);
  - crc4 function over bit [67:0].
- One sub-module alu_rx_deframer: bit FSM only. Outputs pkt_valid pulse, pkt_type and pkt_payload[7:0]. alu_serial_rx does packet sequencing, checks and the output register.

Test Plan:
1. A=0, B=0, 8 data packets of 0x00, cmd payload 0x0B (op 000, crc 1011) -> out_valid one cycle after stop; a=0, b=0, op=000, all errors 0.
2. A=0x01020304, B=0xFFFFFFFF, op ADD, correct crc -> a=0x01020304, b=0xFFFFFFFF, op=100, no errors; out_valid held until out_ready pulses, then falls next cycle.
3. Scenario 1 with cmd payload 0x0A (crc wrong) -> err_crc=1, err_data=0, err_op=0. Then op 010 with correct crc -> err_op=1 only.
4. Six data packets then cmd -> err_data=1, err_crc=0. Next: nine data packets then cmd -> err_data=1. Next: correct frame -> clean result, proving the counter was cleared.
5. Stop bit driven 0 on the fourth data packet, then a full correct frame -> exactly one clean record. Separately: rst_n low mid-payload -> no record, outputs 0.
6. Two full frames back-to-back with out_ready=0 -> second record visible, out_overrun=1 and stays 1 after out_ready.
